// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter slice.
//   - default address/data widths of the 64Kx16 memory
//   - requester port IDs (instruction fetch = 0, load/store = 1)
//   - arbiter FSM state type
package cpu_defs;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory.
//   requester side : req/we/addr/wdata in, gnt/rvalid out, rdata shared
//   memory side    : mem_we/mem_re/mem_addr/mem_wdata out, mem_rdata in
// Modports:
//   slave  - arbiter view
//   master - environment view (requesters + memory)
interface mem_arbiter_if
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              req0,   req1;
  logic              we0,    we1;
  logic [ADDR_W-1:0] addr0,  addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0,   gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
           mem_we, mem_re, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
           mem_we, mem_re, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_burst_ctr.sv
// Saturating consecutive-grant counter.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   i_clr      : count -> 0
//   i_load1    : count -> 1 (new owner)
//   i_inc      : count + 1, holds at MAX_BURST
//   o_sat      : count == MAX_BURST
module arb_burst_ctr #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_load1,
  input  logic i_inc,
  output logic o_sat
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_sat;

  assign w_sat = (r_cnt == CNT_W'(MAX_BURST));
  assign o_sat = w_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (i_clr)            r_cnt <= '0;
    else if (i_load1)          r_cnt <= CNT_W'(1);
    else if (i_inc && !w_sat)  r_cnt <= r_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port 64Kx16 memory.
//   clk, rst_n : clock, async active-low reset
//   bus        : requester handshakes, memory command/read-data (slave view)
// Port 0 = instruction fetch, port 1 = load/store. One command per cycle,
// at most MAX_BURST consecutive grants to one owner while the other waits.
// Grants are combinational; read responses (rvalidX) follow one cycle later.
module mem_arbiter
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  arb_state_e        r_state, w_state_nxt;
  logic              r_last_owner;
  logic              r_rvalid0, r_rvalid1;
  logic              w_gnt0, w_gnt1;
  logic              w_clr, w_load1, w_inc, w_sat;
  logic              w_mem_we, w_mem_re;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  arb_burst_ctr #(.MAX_BURST(MAX_BURST)) u_burst_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_load1 (w_load1),
    .i_inc   (w_inc),
    .o_sat   (w_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Grants are gated by rst_n so nothing reaches the memory while reset is
  // held, even though requesters may keep req asserted.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_clr       = 1'b0;
    w_load1     = 1'b0;
    w_inc       = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.req0 && (!bus.req1 || r_last_owner == PORT_LS)) begin
            w_gnt0      = 1'b1;
            w_load1     = 1'b1;
            w_state_nxt = ST_OWN0;
          end else if (bus.req1) begin
            w_gnt1      = 1'b1;
            w_load1     = 1'b1;
            w_state_nxt = ST_OWN1;
          end
        end
        ST_OWN0: begin
          if (bus.req0 && (!w_sat || !bus.req1)) begin
            w_gnt0 = 1'b1;
            w_inc  = 1'b1;
          end else if (bus.req1) begin
            w_gnt1      = 1'b1;
            w_load1     = 1'b1;
            w_state_nxt = ST_OWN1;
          end else begin
            w_clr       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_OWN1: begin
          if (bus.req1 && (!w_sat || !bus.req0)) begin
            w_gnt1 = 1'b1;
            w_inc  = 1'b1;
          end else if (bus.req0) begin
            w_gnt0      = 1'b1;
            w_load1     = 1'b1;
            w_state_nxt = ST_OWN0;
          end else begin
            w_clr       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_clr       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_gnt0) begin
      w_mem_we    = bus.we0;
      w_mem_re    = ~bus.we0;
      w_mem_addr  = bus.addr0;
      w_mem_wdata = bus.wdata0;
    end else if (w_gnt1) begin
      w_mem_we    = bus.we1;
      w_mem_re    = ~bus.we1;
      w_mem_addr  = bus.addr1;
      w_mem_wdata = bus.wdata1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= PORT_LS;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
    end else begin
      if (w_gnt0)      r_last_owner <= PORT_IF;
      else if (w_gnt1) r_last_owner <= PORT_LS;
      r_rvalid0 <= w_gnt0 & ~bus.we0;
      r_rvalid1 <= w_gnt1 & ~bus.we1;
    end
  end

  assign bus.gnt0      = w_gnt0;
  assign bus.gnt1      = w_gnt1;
  assign bus.rvalid0   = r_rvalid0;
  assign bus.rvalid1   = r_rvalid1;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_re    = w_mem_re;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random
// traffic compared against a grant/scoreboard model of the arbitration rules.
module tb_mem_arbiter;
  import cpu_defs::*;

  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0]  t_req, t_we;
  logic [15:0] t_addr [2];
  logic [15:0] t_wdata[2];

  int n_total = 0;
  int n_bad   = 0;

  // model state
  int          m_prev;     // owner granted last cycle, -1 if none
  int          m_streak;   // consecutive grants to m_prev
  int          m_last;     // most recent owner ever granted
  logic [1:0]  m_rv;
  logic [15:0] m_rdata;
  logic [15:0] shadow [0:65535] = '{default: '0};

  // memory behind the arbiter
  logic [15:0] mem [0:65535] = '{default: '0};
  logic [15:0] mem_q = '0;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.req0      = t_req[0];
  assign bus.req1      = t_req[1];
  assign bus.we0       = t_we[0];
  assign bus.we1       = t_we[1];
  assign bus.addr0     = t_addr[0];
  assign bus.addr1     = t_addr[1];
  assign bus.wdata0    = t_wdata[0];
  assign bus.wdata1    = t_wdata[1];
  assign bus.mem_rdata = mem_q;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) mem_q <= mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant(logic r0, logic r1);
    if (!r0 && !r1)    return -1;
    if (r0 != r1)      return r0 ? 0 : 1;
    if (m_prev < 0)    return 1 - m_last;
    if (m_streak < MAXB) return m_prev;
    return 1 - m_prev;
  endfunction

  task automatic model_reset();
    m_prev   = -1;
    m_streak = 0;
    m_last   = 1;
    m_rv     = 2'b00;
    m_rdata  = '0;
  endtask

  task automatic set_cmd(input int p, input logic we, input logic [15:0] a, input logic [15:0] d);
    t_req[p]   = 1'b1;
    t_we[p]    = we;
    t_addr[p]  = a;
    t_wdata[p] = d;
  endtask

  // One clock: check outputs mid-cycle, advance the model, drop the granted req.
  task automatic step(output int g);
    int gg;
    @(negedge clk);
    gg = model_grant(t_req[0], t_req[1]);
    chk("gnt0", 32'(bus.gnt0), 32'(gg == 0));
    chk("gnt1", 32'(bus.gnt1), 32'(gg == 1));
    chk("onehot", 32'(bus.gnt0 & bus.gnt1), 32'(0));
    chk("rvalid0", 32'(bus.rvalid0), 32'(m_rv[0]));
    chk("rvalid1", 32'(bus.rvalid1), 32'(m_rv[1]));
    if (m_rv != 2'b00) chk("rdata", 32'(bus.rdata), 32'(m_rdata));
    if (gg >= 0) begin
      chk("mem_we", 32'(bus.mem_we), 32'(t_we[gg]));
      chk("mem_re", 32'(bus.mem_re), 32'(!t_we[gg]));
      chk("mem_addr", 32'(bus.mem_addr), 32'(t_addr[gg]));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(t_wdata[gg]));
    end else begin
      chk("mem_we_idle", 32'(bus.mem_we), 32'(0));
      chk("mem_re_idle", 32'(bus.mem_re), 32'(0));
      chk("mem_addr_idle", 32'(bus.mem_addr), 32'(0));
      chk("mem_wdata_idle", 32'(bus.mem_wdata), 32'(0));
    end
    m_rv = 2'b00;
    if (gg >= 0) begin
      if (t_we[gg]) shadow[t_addr[gg]] = t_wdata[gg];
      else begin
        m_rv[gg] = 1'b1;
        m_rdata  = shadow[t_addr[gg]];
      end
      m_streak = (gg == m_prev) ? m_streak + 1 : 1;
      m_prev   = gg;
      m_last   = gg;
    end else begin
      m_prev   = -1;
      m_streak = 0;
    end
    @(posedge clk);
    #1;
    if (gg >= 0) t_req[gg] = 1'b0;
    g = gg;
  endtask

  task automatic idle_steps(input int n);
    int g;
    t_req = 2'b00;
    for (int i = 0; i < n; i++) step(g);
  endtask

  initial begin
    int g;
    int first;
    rst_n = 1'b0;
    model_reset();
    set_cmd(0, 1'b0, 16'h0000, 16'h0000);
    set_cmd(1, 1'b0, 16'h0000, 16'h0000);

    // reset held with both requesting
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_gnt0", 32'(bus.gnt0), 32'(0));
      chk("rst_gnt1", 32'(bus.gnt1), 32'(0));
      chk("rst_mem_we", 32'(bus.mem_we), 32'(0));
      chk("rst_mem_re", 32'(bus.mem_re), 32'(0));
      chk("rst_rvalid", 32'({bus.rvalid1, bus.rvalid0}), 32'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(g);
    chk("t1_first_gnt", 32'(g), 32'(0));
    step(g);
    chk("t1_second_gnt", 32'(g), 32'(1));
    idle_steps(2);

    // write on port 1, read back on port 0 the next cycle
    set_cmd(1, 1'b1, 16'h0040, 16'hBEEF);
    step(g);
    chk("t2_wr_gnt", 32'(g), 32'(1));
    set_cmd(0, 1'b0, 16'h0040, 16'h0000);
    step(g);
    chk("t2_rd_gnt", 32'(g), 32'(0));
    chk("t2_rvalid0", 32'(bus.rvalid0), 32'(1));
    chk("t2_rdata", 32'(bus.rdata), 32'(16'hBEEF));
    idle_steps(2);

    // both hold requests: bursts of MAXB alternate; port 0 was last owner
    first = 1;
    for (int i = 0; i < 3 * MAXB; i++) begin
      set_cmd(0, 1'b0, 16'(i), 16'h0);
      set_cmd(1, 1'b0, 16'(i + 8), 16'h0);
      step(g);
      chk("t3_seq", 32'(g), 32'(first ^ ((i / MAXB) % 2)));
    end
    idle_steps(2);

    // only port 1 for 10 cycles: never forced off, counter saturates
    for (int i = 0; i < 10; i++) begin
      set_cmd(1, 1'b1, 16'(32 + i), 16'($urandom));
      step(g);
      chk("t4_only1", 32'(g), 32'(1));
    end
    chk("t4_cnt_sat", 32'(dut.u_burst_ctr.r_cnt), 32'(MAXB));
    set_cmd(0, 1'b0, 16'h0020, 16'h0);
    set_cmd(1, 1'b0, 16'h0021, 16'h0);
    step(g);
    chk("t4_switch", 32'(g), 32'(0));
    idle_steps(3);

    // reset pulse right after a read grant drops the response
    set_cmd(0, 1'b1, 16'h0007, 16'h1234);
    step(g);
    set_cmd(0, 1'b0, 16'h0007, 16'h0);
    step(g);
    chk("t5_rd_gnt", 32'(g), 32'(0));
    rst_n = 1'b0;
    #1;
    chk("t5_rvalid_drop", 32'(bus.rvalid0), 32'(0));
    chk("t5_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    model_reset();
    t_req = 2'b00;
    idle_steps(1);
    set_cmd(1, 1'b0, 16'h0007, 16'h0);
    step(g);
    chk("t5_rd_after_rst", 32'(g), 32'(1));
    chk("t5_mem_intact", 32'(bus.rdata), 32'(16'h1234));
    idle_steps(1);

    // random traffic on both ports
    for (int i = 0; i < 2000; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!t_req[p] && $urandom_range(0, 99) < 60)
          set_cmd(p, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
      end
      step(g);
    end
    idle_steps(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
